// File: rtl/ahb_master_module_pkg.sv
// Shared AHB encodings, master FSM state encoding and the default data-phase
// timeout used by the single-transfer AHB master.
package ahb_master_module_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/ahb_master_module_wait_timer.sv
// Data-phase wait counter: counts hready-low cycles and flags when TIMEOUT is reached.
module ahb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at TIMEOUT so an unexpected extra enable cannot wrap to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/ahb_master_module.sv
// Single-transfer AHB master: accepts one local command, arbitrates for the bus,
// runs one NONSEQ transfer with a data-phase timeout and returns a one-cycle response.
module ahb_master_module
  import ahb_master_module_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        hbusreq,
  input  logic        hgrant,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [1:0]  htrans,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata
);

  state_e      state_q, state_d;
  logic        cmd_ready_q;
  logic        wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] haddr_q, hwdata_q;
  logic        hwrite_q;
  logic [31:0] rdata_q;
  logic        err_q, to_q;
  logic        accept, enter_addr, enter_data, data_done, tc;

  assign accept     = cmd_valid && cmd_ready_q;
  assign enter_addr = (state_q == ST_REQ) && hgrant && hready;
  assign enter_data = (state_q == ST_ADDR) && hready;
  // hready wins over the terminal count, so a late slave still completes normally.
  assign data_done  = (state_q == ST_DATA) && (hready || tc);

  ahb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i  (hclk),
    .rst_ni (hresetn),
    .clr_i  (enter_data),
    .en_i   ((state_q == ST_DATA) && !hready),
    .tc_o   (tc)
  );

  always_comb begin
    state_d   = state_q;
    htrans    = HTRANS_IDLE;
    hbusreq   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ: begin
        hbusreq = 1'b1;
        if (hgrant && hready) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        hbusreq = 1'b1;
        htrans  = HTRANS_NONSEQ;
        if (hready) state_d = ST_DATA;
      end
      ST_DATA: if (hready || tc) state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      if (accept) begin
        wr_q    <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      // Bus-facing address/data only change when their phase starts.
      if (enter_addr) begin
        haddr_q  <= addr_q;
        hwrite_q <= wr_q;
      end
      if (enter_data && wr_q) begin
        hwdata_q <= wdata_q;
      end
      if (data_done) begin
        rdata_q <= (hready && !wr_q) ? hrdata : '0;
        err_q   <= hready ? (hresp == HRESP_ERROR) : 1'b1;
        to_q    <= !hready;
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign haddr       = haddr_q;
  assign hwrite      = hwrite_q;
  assign hwdata      = hwdata_q;
  assign rsp_rdata   = rsp_valid ? rdata_q : '0;
  assign rsp_error   = rsp_valid && err_q;
  assign rsp_timeout = rsp_valid && to_q;

endmodule

// File: tb/tb_ahb_master_module.sv
// Bench for ahb_master_module: directed and randomized single transfers against a
// per-transaction timeline model derived from grant delay, wait states and timeout.
module tb_ahb_master_module;

  localparam int TO = 16;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cmd_valid, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        cmd_ready;
  logic        rsp_valid, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        hbusreq, hgrant, hwrite, hready, hresp;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev_addr = '0;

  always #5 hclk = ~hclk;

  ahb_master_module #(.TIMEOUT(TO)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .rsp_timeout (rsp_timeout),
    .hbusreq     (hbusreq),
    .hgrant      (hgrant),
    .haddr       (haddr),
    .hwrite      (hwrite),
    .htrans      (htrans),
    .hwdata      (hwdata),
    .hready      (hready),
    .hresp       (hresp),
    .hrdata      (hrdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer: g edges without grant, a address-phase waits, w data-phase waits.
  // Expected response: completes after min(w,TO) waits; w > TO means timeout.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, input logic resp,
                      input int g, input int a, input int w);
    int   m, len;
    logic to;
    m   = (w > TO) ? TO : w;
    to  = (w > TO);
    len = 4 + g + a + m;
    @(negedge hclk);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_hbusreq", hbusreq, 0);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    hrdata    = rd;
    hresp     = resp;
    for (int k = 1; k <= len + 1; k++) begin
      hgrant = (k >= g + 2);
      hready = !((k >= g + 3 && k <= g + 2 + a) ||
                 (k >= g + 4 + a && k <= g + 3 + a + m) ||
                 (k == len && to));
      @(posedge hclk);
      @(negedge hclk);
      if (k == 1) cmd_valid = 1'b0;
      if (k <= g + 1) begin
        chk("req_hbusreq", hbusreq, 1);
        chk("req_htrans", htrans, 2'b00);
        chk("req_haddr_hold", haddr, prev_addr);
        chk("req_cmd_ready", cmd_ready, 0);
        chk("req_rsp_valid", rsp_valid, 0);
      end else if (k <= g + 2 + a) begin
        chk("addr_htrans", htrans, 2'b10);
        chk("addr_hbusreq", hbusreq, 1);
        chk("addr_haddr", haddr, addr);
        chk("addr_hwrite", hwrite, wr);
        chk("addr_rsp_valid", rsp_valid, 0);
      end else if (k < len) begin
        chk("data_htrans", htrans, 2'b00);
        chk("data_hbusreq", hbusreq, 0);
        if (wr) chk("data_hwdata", hwdata, wd);
        chk("data_rsp_valid", rsp_valid, 0);
      end else if (k == len) begin
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, (wr || to) ? 32'h0 : rd);
        chk("rsp_error", rsp_error, to | resp);
        chk("rsp_timeout", rsp_timeout, to);
        chk("rsp_cmd_ready", cmd_ready, 0);
        chk("rsp_haddr_hold", haddr, addr);
      end else begin
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_htrans", htrans, 2'b00);
      end
    end
    prev_addr = addr;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hresetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    hgrant    = 1'b0;
    hready    = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    repeat (3) @(negedge hclk);
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_hbusreq", hbusreq, 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_hwrite", hwrite, 0);
    chk("rst_hwdata", hwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    hresetn = 1'b1;
    #1;
    chk("rel_cmd_ready_pre", cmd_ready, 0);
    @(negedge hclk);
    chk("rel_cmd_ready_first_edge", cmd_ready, 1);

    // Directed scenarios
    xfer(1'b1, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, 0, 0, 0);
    xfer(1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, 0, 0, 3);
    xfer(1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 5, 0, 0);
    xfer(1'b1, 32'h24, 32'h11112222, 32'h0, 1'b1, 0, 0, 0);
    xfer(1'b0, 32'h28, 32'h0, 32'hA5A5A5A5, 1'b1, 1, 2, 1);
    xfer(1'b0, 32'h30, 32'h0, 32'h55AA55AA, 1'b0, 0, 0, 40);
    xfer(1'b1, 32'h34, 32'h0BADCAFE, 32'h0, 1'b0, 0, 0, 0);
    xfer(1'b0, 32'h38, 32'h0, 32'h87654321, 1'b0, 0, 0, TO);
    xfer(1'b0, 32'h3C, 32'h0, 32'h13579BDF, 1'b0, 0, 0, TO + 1);

    // Reset during the address phase aborts the transfer
    @(negedge hclk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h40;
    cmd_wdata = 32'hFEEDFACE;
    hgrant    = 1'b1;
    hready    = 1'b1;
    @(negedge hclk);
    cmd_valid = 1'b0;
    @(negedge hclk);
    hready = 1'b0;
    chk("abort_in_addr", htrans, 2'b10);
    #2;
    hresetn = 1'b0;
    #1;
    chk("abort_htrans", htrans, 2'b00);
    chk("abort_hbusreq", hbusreq, 0);
    chk("abort_haddr", haddr, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    @(negedge hclk);
    hresetn = 1'b1;
    hready  = 1'b1;
    hgrant  = 1'b0;
    prev_addr = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge hclk);
      if (i == 0) chk("abort_release_cmd_ready", cmd_ready, 1);
      chk("abort_no_rsp", rsp_valid, 0);
      chk("abort_no_busreq", hbusreq, 0);
    end

    // Randomized transfers
    for (int i = 0; i < 30; i++) begin
      int w;
      w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 2, TO + 4))
                                      : int'($urandom_range(0, 4));
      xfer(1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 2)), w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
